fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Fetch-stage PC sequencer. Owns the PC register and drives pc_sel with pc+4 or a redirect target.
//  Arbitrates redirect sources (trap > branch), hazard stall and the imem request/ready handshake.
//  Emits a flush to IF/ID when a redirect kills the in-flight fetch. Sits between hazard/EX/CSR logic and imem.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset (default from defines pkg)
//  DATA_WIDTH    32             address width (from defines pkg)
// PORTS
//  clk                   in   1           single clock, rising edge
//  rst                   in   1           synchronous, active-high reset
//  stall_i               in   1           hazard stall: hold PC, no new request
//  PCSrc_i               in   1           EX branch/jump taken
//  branch_target_addr_i  in   DATA_WIDTH  EX redirect target
//  trap_i                in   1           trap/exception redirect
//  trap_vec_i            in   DATA_WIDTH  trap handler address
//  imem_ready_i          in   1           imem accepts current request
//  imem_req_o            out  1           fetch request valid
//  pc_o                  out  DATA_WIDTH  current fetch address (= imem addr)
//  pc_plus4_o            out  DATA_WIDTH  pc_o + 4
//  flush_o               out  1           kill IF/ID contents this cycle
//  fetch_valid_o         out  1           pc_o fetch accepted this cycle (req && ready && !flush)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. All outputs registered except fetch_valid_o, pc_plus4_o.
//  Reset: pc_o=RESET_VECTOR, imem_req_o=0, flush_o=0, pending cleared, state=BOOT.
//  FSM states (pc_state_e): BOOT, FETCH, WAIT, HOLD.
//   BOOT : 1 cycle after rst deasserts, req=0 -> FETCH.
//   FETCH: req=1. ready=1 -> pc_o<=next_pc. ready=0 -> WAIT. stall_i=1 (no redirect) -> HOLD, req=0 next cycle.
//   WAIT : req=1, pc_o held stable until ready (address must not change while req && !ready).
//   HOLD : req=0, pc_o held; stall_i=0 -> FETCH.
//  next_pc: trap_i ? trap_vec_i : PCSrc_i ? branch_target_addr_i : pc_o+4 (via pc_sel). Adds wrap mod 2^32.
//  Redirect in FETCH/HOLD: applied next edge (pc_o<=target), flush_o=1 one cycle, state FETCH.
//  Redirect in WAIT: target latched in pending reg (trap overwrites pending branch, branch never overwrites pending trap);
//   on accept, pc_o<=pending target, flush_o=1 one cycle, pending cleared. The accepted fetch is discarded.
//  Redirect overrides stall_i in the same cycle. trap_i and PCSrc_i together: trap wins.
//  Stall while WAIT: request stays up until ready (handshake not abandoned), then HOLD.
//  rst mid-operation: immediate return to reset values; pending redirect dropped.
// CONFIGURATION
//  PC_MISALIGN_CHECK_EN defined: redirect target with [1:0]!=0 is not taken; pc_o<=trap_vec_i,
//   extra output misalign_o pulses 1 cycle (reset 0). Undefined: port absent, low bits taken unchanged.
// STRUCTURE
//  defines pkg: DATA_WIDTH, RESET_VECTOR, typedef enum logic[1:0] pc_state_e {BOOT,FETCH,WAIT,HOLD}.
//  Sub-module: pc_sel instance selects pc_plus4 vs redirect target; trap priority muxed ahead of it.
// TESTING
//  1 rst 2 cycles, ready=1 -> cycle after BOOT pc_o=0x0, then 0x4, 0x8; imem_req_o=1, flush_o=0.
//  2 pc_o=0x100, PCSrc_i=1 target=0x200 -> next pc_o=0x200, flush_o=1 for exactly 1 cycle, then 0x204.
//  3 pc_o=0x100, ready=0 3 cycles, branch to 0x400 in cycle 1 -> pc_o stays 0x100 until ready, then 0x400, flush_o=1.
//  4 trap_i=1 vec=0x80 with PCSrc_i=1 target=0x200 same cycle -> pc_o=0x80; stall_i=1 same cycle ignored.
//  5 stall_i=1 2 cycles at pc_o=0x10 -> req=0, pc_o=0x10 held; release -> 0x10 refetched, then 0x14.
//  6 pc_o=0xFFFF_FFFC sequential -> wraps to 0x0; with PC_MISALIGN_CHECK_EN, target 0x202 -> misalign_o=1, pc_o=trap_vec_i.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared width, reset vector and FSM state type for the fetch PC sequencer
package fetch_pc_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} pc_state_e;
endpackage

// File: rtl/fetch_pc_ctrl_pc_sel.sv
// fetch_pc_ctrl_pc_sel: picks pc+4 or redirect target (ports: pc, redirect, target in; pc_plus4, next_pc out)
module fetch_pc_ctrl_pc_sel
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] pc,
  input  logic         redirect,
  input  logic [W-1:0] target,
  output logic [W-1:0] pc_plus4,
  output logic [W-1:0] next_pc
);
  assign pc_plus4 = pc + W'(4);
  assign next_pc  = redirect ? target : pc_plus4;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC sequencer; ports clk, rst, stall_i, PCSrc_i, branch_target_addr_i, trap_i, trap_vec_i, imem_ready_i -> imem_req_o, pc_o, pc_plus4_o, flush_o, fetch_valid_o (+ misalign_o when PC_MISALIGN_CHECK_EN)
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int                    W            = DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VEC    = RESET_VECTOR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         PCSrc_i,
  input  logic [W-1:0] branch_target_addr_i,
  input  logic         trap_i,
  input  logic [W-1:0] trap_vec_i,
  input  logic         imem_ready_i,
  output logic         imem_req_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o,
  output logic         flush_o,
`ifdef PC_MISALIGN_CHECK_EN
  output logic         misalign_o,
`endif
  output logic         fetch_valid_o
);
  pc_state_e state, state_n;
  logic [W-1:0] pc_n, pend_tgt, pend_tgt_n, raw_tgt, tgt, next_pc;
  logic req_n, flush_n, pend_v, pend_v_n, pend_trap, pend_trap_n, redir;
  assign redir = trap_i | PCSrc_i | pend_v;
  // a pending trap outranks a fresh branch; a fresh branch replaces a pending branch
  assign raw_tgt = trap_i ? trap_vec_i : (pend_v && pend_trap) ? pend_tgt : PCSrc_i ? branch_target_addr_i : pend_tgt;
`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = !(trap_i || (pend_v && pend_trap)) && |raw_tgt[1:0];
  assign tgt = misaligned ? trap_vec_i : raw_tgt;
  always_ff @(posedge clk) misalign_o <= !rst && flush_n && misaligned;
`else
  assign tgt = raw_tgt;
`endif
  fetch_pc_ctrl_pc_sel #(.W(W)) u_pc_sel (
    .pc       (pc_o),
    .redirect (redir),
    .target   (tgt),
    .pc_plus4 (pc_plus4_o),
    .next_pc  (next_pc)
  );
  assign fetch_valid_o = imem_req_o & imem_ready_i & ~flush_o;
  always_comb begin
    state_n     = state;
    pc_n        = pc_o;
    req_n       = imem_req_o;
    flush_n     = 1'b0;
    pend_v_n    = pend_v;
    pend_trap_n = pend_trap;
    pend_tgt_n  = pend_tgt;
    case (state)
      BOOT: begin
        state_n = FETCH;
        req_n   = 1'b1;
      end
      FETCH, WAIT: if (!imem_ready_i) begin
        // address is frozen while the request is outstanding; redirects wait in the pending reg
        state_n = WAIT;
        if (trap_i || (PCSrc_i && !(pend_v && pend_trap))) begin
          pend_v_n    = 1'b1;
          pend_trap_n = trap_i;
          pend_tgt_n  = trap_i ? trap_vec_i : branch_target_addr_i;
        end
      end else begin
        pend_v_n = 1'b0;
        state_n  = (!redir && stall_i) ? HOLD : FETCH;
        req_n    = redir || !stall_i;
        pc_n     = (redir || !stall_i) ? next_pc : pc_o;
        flush_n  = redir;
      end
      HOLD: begin
        state_n = (redir || !stall_i) ? FETCH : HOLD;
        req_n   = redir || !stall_i;
        pc_n    = redir ? next_pc : pc_o;
        flush_n = redir;
      end
      default: state_n = BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc_o       <= RESET_VEC;
      imem_req_o <= 1'b0;
      flush_o    <= 1'b0;
      pend_v     <= 1'b0;
      pend_trap  <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_n;
      pc_o       <= pc_n;
      imem_req_o <= req_n;
      flush_o    <= flush_n;
      pend_v     <= pend_v_n;
      pend_trap  <= pend_trap_n;
      pend_tgt   <= pend_tgt_n;
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
  logic clk = 1'b0, rst, stall_i, PCSrc_i, trap_i, imem_ready_i;
  logic [31:0] branch_target_addr_i, trap_vec_i;
  logic imem_req_o, flush_o, fetch_valid_o;
  logic [31:0] pc_o, pc_plus4_o;
  int n_chk = 0, n_fail = 0;
`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_o;
`endif
  always #5 clk = ~clk;
  fetch_pc_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .PCSrc_i              (PCSrc_i),
    .branch_target_addr_i (branch_target_addr_i),
    .trap_i               (trap_i),
    .trap_vec_i           (trap_vec_i),
    .imem_ready_i         (imem_ready_i),
    .imem_req_o           (imem_req_o),
    .pc_o                 (pc_o),
    .pc_plus4_o           (pc_plus4_o),
    .flush_o              (flush_o),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign_o           (misalign_o),
`endif
    .fetch_valid_o        (fetch_valid_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic branch(input logic [31:0] t);
    PCSrc_i = 1'b1;
    branch_target_addr_i = t;
    step();
    PCSrc_i = 1'b0;
  endtask
  initial begin
    rst = 1'b1; stall_i = 1'b0; PCSrc_i = 1'b0; trap_i = 1'b0; imem_ready_i = 1'b1;
    branch_target_addr_i = '0; trap_vec_i = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    rst = 1'b0;
    step();
    check("boot_pc", pc_o, 32'h0);
    check("boot_req", 32'(imem_req_o), 32'h1);
    check("boot_fv", 32'(fetch_valid_o), 32'h1);
    check("boot_p4", pc_plus4_o, 32'h4);
    step(); check("seq_4", pc_o, 32'h4);
    step(); check("seq_8", pc_o, 32'h8);
    check("seq_flush", 32'(flush_o), 32'h0);
    branch(32'hFC); step();
    check("br_pre", pc_o, 32'h100);
    branch(32'h200);
    check("br_pc", pc_o, 32'h200);
    check("br_flush", 32'(flush_o), 32'h1);
    check("br_fv", 32'(fetch_valid_o), 32'h0);
    step();
    check("br_next", pc_o, 32'h204);
    check("br_flush_end", 32'(flush_o), 32'h0);
    branch(32'h100);
    imem_ready_i = 1'b0;
    branch(32'h400);
    check("wait_pc1", pc_o, 32'h100);
    check("wait_req", 32'(imem_req_o), 32'h1);
    check("wait_fv", 32'(fetch_valid_o), 32'h0);
    step(); check("wait_pc2", pc_o, 32'h100);
    step(); check("wait_pc3", pc_o, 32'h100);
    imem_ready_i = 1'b1;
    step();
    check("wait_redir", pc_o, 32'h400);
    check("wait_flush", 32'(flush_o), 32'h1);
    step(); check("wait_after", pc_o, 32'h404);
    trap_i = 1'b1; trap_vec_i = 32'h80; stall_i = 1'b1;
    branch(32'h200);
    trap_i = 1'b0; stall_i = 1'b0;
    check("trap_pc", pc_o, 32'h80);
    check("trap_flush", 32'(flush_o), 32'h1);
    check("trap_req", 32'(imem_req_o), 32'h1);
    step(); check("trap_after", pc_o, 32'h84);
    branch(32'h10);
    stall_i = 1'b1;
    step();
    check("stall_req1", 32'(imem_req_o), 32'h0);
    check("stall_pc1", pc_o, 32'h10);
    step();
    check("stall_req2", 32'(imem_req_o), 32'h0);
    check("stall_pc2", pc_o, 32'h10);
    check("stall_fv", 32'(fetch_valid_o), 32'h0);
    stall_i = 1'b0;
    step();
    check("stall_refetch", pc_o, 32'h10);
    check("stall_req3", 32'(imem_req_o), 32'h1);
    step(); check("stall_next", pc_o, 32'h14);
    imem_ready_i = 1'b0; trap_i = 1'b1; trap_vec_i = 32'h300;
    step();
    trap_i = 1'b0;
    branch(32'h500);
    imem_ready_i = 1'b1;
    step();
    check("pend_trap_kept", pc_o, 32'h300);
    imem_ready_i = 1'b0;
    branch(32'h600);
    trap_i = 1'b1; trap_vec_i = 32'h340;
    step();
    trap_i = 1'b0; imem_ready_i = 1'b1;
    step();
    check("pend_trap_over", pc_o, 32'h340);
    imem_ready_i = 1'b0;
    branch(32'h700);
    rst = 1'b1;
    step();
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_req", 32'(imem_req_o), 32'h0);
    rst = 1'b0; imem_ready_i = 1'b1;
    step(); check("mid_boot_pc", pc_o, 32'h0);
    step();
    check("mid_drop_pc", pc_o, 32'h4);
    check("mid_drop_flush", 32'(flush_o), 32'h0);
    branch(32'hFFFF_FFFC);
    check("wrap_pre", pc_o, 32'hFFFF_FFFC);
    step(); check("wrap_pc", pc_o, 32'h0);
    trap_vec_i = 32'h80;
    branch(32'h202);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_pc", pc_o, 32'h80);
    check("mis_pulse", 32'(misalign_o), 32'h1);
    step();
    check("mis_end", 32'(misalign_o), 32'h0);
    check("mis_next", pc_o, 32'h84);
`else
    check("unal_pc", pc_o, 32'h202);
    step(); check("unal_next", pc_o, 32'h206);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
